// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states, field widths and enable patterns.
// Used by the stall sequencer and its counter sub-module.
package pipe_ctrl_pkg;

  localparam int HZ_DEPTH_W  = 2;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, ex_mem_write: 1'b1};
  localparam pipe_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, ex_mem_write: 1'b0};
  localparam pipe_ctl_t CTL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_bubble: 1'b1, ex_mem_write: 1'b1};
  localparam pipe_ctl_t CTL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b1, ex_mem_write: 1'b1};
  localparam pipe_ctl_t CTL_IMISS  = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_bubble: 1'b0, ex_mem_write: 1'b1};
  localparam pipe_ctl_t CTL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                       id_ex_bubble: 1'b1, ex_mem_write: 1'b0};

  // A requested depth of 0 still costs one bubble.
  function automatic logic [HZ_DEPTH_W-1:0] eff_depth(input logic [HZ_DEPTH_W-1:0] d);
    return (d == '0) ? HZ_DEPTH_W'(1) : d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; increments one cycle after inc_en.
// No backpressure: holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (inc_en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall/flush sequencer: register enables, flushes and bubbles from hazard/memory events.
// Outputs are combinational (zero latency); a busy data memory freezes everything and parks the stall state.
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hz_req,
  input  logic [HZ_DEPTH_W-1:0]  hz_depth,
  input  logic                   branch_flush,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  output logic                   PC_write,
  output logic                   IF_ID_write,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_bubble,
  output logic                   EX_MEM_write,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  pipe_state_e           state_q, state_d;
  pipe_state_e           saved_q, saved_d;
  pipe_state_e           resume;
  logic [HZ_DEPTH_W-1:0] cnt_q, cnt_d;
  logic [HZ_DEPTH_W-1:0] depth;
  pipe_ctl_t             ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctl     = CTL_NORMAL;
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    depth   = eff_depth(hz_depth);
    // While parked in MEM_WAIT, the state to resume decides this cycle's behaviour.
    resume  = (state_q == MEM_WAIT) ? saved_q : state_q;

    if (!dmem_ready) begin
      ctl     = CTL_FREEZE;
      state_d = MEM_WAIT;
      saved_d = resume;
    end else if (branch_flush) begin
      ctl     = CTL_FLUSH;
      state_d = RUN;
      saved_d = RUN;
      cnt_d   = '0;
    end else if (resume == HAZ_STALL) begin
      ctl     = CTL_BUBBLE;
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      state_d = (cnt_q <= HZ_DEPTH_W'(1)) ? RUN : HAZ_STALL;
      saved_d = RUN;
    end else if (hz_req) begin
      ctl     = CTL_BUBBLE;
      cnt_d   = depth - 1'b1;
      state_d = (depth > HZ_DEPTH_W'(1)) ? HAZ_STALL : RUN;
      saved_d = RUN;
    end else if (!imem_ready) begin
      ctl     = CTL_IMISS;
      state_d = RUN;
      saved_d = RUN;
    end else begin
      state_d = RUN;
      saved_d = RUN;
    end

    // Reset overrides outputs immediately, independent of any clock edge.
    if (!rst_n) begin
      ctl = CTL_RESET;
    end
  end

  assign PC_write     = ctl.pc_write;
  assign IF_ID_write  = ctl.if_id_write;
  assign IF_ID_flush  = ctl.if_id_flush;
  assign ID_EX_bubble = ctl.id_ex_bubble;
  assign EX_MEM_write = ctl.ex_mem_write;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .clr_n  (rst_n),
    .inc_en (rst_n && !ctl.pc_write),
    .count  (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Bench for pipeline_stall_sequencer: directed vector table, reset corner, random run vs model, saturation.
module tb_pipeline_stall_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hz_req;
  logic [1:0]  hz_depth;
  logic        branch_flush;
  logic        imem_ready;
  logic        dmem_ready;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write;
  logic [15:0] stall_cycles;

  pipeline_stall_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_req       (hz_req),
    .hz_depth     (hz_depth),
    .branch_flush (branch_flush),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_bubble (ID_EX_bubble),
    .EX_MEM_write (EX_MEM_write),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Expected control patterns, bit order {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write}.
  localparam logic [4:0] E_NORM = 5'b11001;
  localparam logic [4:0] E_BUB  = 5'b00011;
  localparam logic [4:0] E_FLU  = 5'b11111;
  localparam logic [4:0] E_FRZ  = 5'b00000;
  localparam logic [4:0] E_IMS  = 5'b01101;
  localparam logic [4:0] E_RST  = 5'b00110;

  typedef struct packed {
    logic        hz;
    logic [1:0]  dep;
    logic        br;
    logic        im;
    logic        dm;
    logic [4:0]  ctl;
    logic [15:0] sc;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  int nvec = 0;
  int nmis = 0;
  int m_bub = 0;
  int m_cnt = 0;

  function automatic vec_t v(logic hz, logic [1:0] dep, logic br, logic im, logic dm,
                             logic [4:0] ctl, int sc);
    vec_t r;
    r.hz = hz; r.dep = dep; r.br = br; r.im = im; r.dm = dm;
    r.ctl = ctl; r.sc = 16'(sc);
    return r;
  endfunction

  task automatic drive(logic hz, logic [1:0] dep, logic br, logic im, logic dm);
    hz_req = hz; hz_depth = dep; branch_flush = br; imem_ready = im; dmem_ready = dm;
  endtask

  task automatic chk(string nm, logic [4:0] ectl, logic [15:0] esc);
    logic [4:0] act;
    act = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write};
    nvec++;
    if ({act, stall_cycles} !== {ectl, esc}) begin
      nmis++;
      $display("FAIL %s: got ctl=%b stall_cycles=%h, expected ctl=%b stall_cycles=%h",
               nm, act, stall_cycles, ectl, esc);
    end
  endtask

  // Reference: pending bubbles are just a number; memory-busy cycles leave it untouched.
  task automatic model(logic hz, logic [1:0] dep, logic br, logic im, logic dm,
                       output logic [4:0] e);
    if (!dm) e = E_FRZ;
    else if (br) begin e = E_FLU; m_bub = 0; end
    else if (m_bub > 0) begin e = E_BUB; m_bub--; end
    else if (hz) begin e = E_BUB; m_bub = ((dep == 2'd0) ? 1 : int'(dep)) - 1; end
    else if (!im) e = E_IMS;
    else e = E_NORM;
  endtask

  task automatic model_step(string nm, logic hz, logic [1:0] dep, logic br, logic im, logic dm);
    logic [4:0] e;
    model(hz, dep, br, im, dm, e);
    chk(nm, e, 16'(m_cnt));
    if (!e[4] && m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    // hz, dep, br, im, dm, expected ctl, expected stall_cycles
    tbl[0]  = v(1, 2, 0, 1, 1, E_BUB, 0);   // depth-2 hazard
    tbl[1]  = v(0, 0, 0, 1, 1, E_BUB, 1);
    tbl[2]  = v(0, 0, 0, 1, 1, E_NORM, 2);
    tbl[3]  = v(1, 3, 0, 1, 1, E_BUB, 2);   // depth 3, flushed in second stall cycle
    tbl[4]  = v(0, 0, 1, 1, 1, E_FLU, 3);
    tbl[5]  = v(0, 0, 0, 1, 1, E_NORM, 3);
    tbl[6]  = v(1, 3, 0, 1, 1, E_BUB, 3);   // depth 3, memory busy from stall cycle 2
    tbl[7]  = v(0, 0, 0, 1, 0, E_FRZ, 4);
    tbl[8]  = v(0, 0, 0, 1, 0, E_FRZ, 5);
    tbl[9]  = v(0, 0, 0, 1, 0, E_FRZ, 6);
    tbl[10] = v(0, 0, 0, 1, 0, E_FRZ, 7);
    tbl[11] = v(0, 0, 0, 1, 1, E_BUB, 8);
    tbl[12] = v(0, 0, 0, 1, 1, E_BUB, 9);
    tbl[13] = v(0, 0, 0, 1, 1, E_NORM, 10);
    tbl[14] = v(0, 0, 0, 0, 1, E_IMS, 10);  // instruction fetch miss x3
    tbl[15] = v(0, 0, 0, 0, 1, E_IMS, 11);
    tbl[16] = v(0, 0, 0, 0, 1, E_IMS, 12);
    tbl[17] = v(0, 0, 0, 1, 1, E_NORM, 13);
    tbl[18] = v(1, 0, 0, 1, 1, E_BUB, 13);  // depth 0 acts as 1
    tbl[19] = v(0, 0, 0, 1, 1, E_NORM, 14);
    tbl[20] = v(1, 1, 0, 1, 1, E_BUB, 14);
    tbl[21] = v(0, 0, 0, 1, 1, E_NORM, 15);
    tbl[22] = v(1, 3, 0, 1, 1, E_BUB, 15);  // hz_req held during stall must not re-arm
    tbl[23] = v(1, 3, 0, 1, 1, E_BUB, 16);
    tbl[24] = v(1, 3, 0, 1, 1, E_BUB, 17);
    tbl[25] = v(0, 0, 0, 1, 1, E_NORM, 18);
    tbl[26] = v(1, 2, 1, 0, 0, E_FRZ, 18);  // priority ladder
    tbl[27] = v(1, 2, 1, 0, 1, E_FLU, 19);
    tbl[28] = v(1, 2, 0, 0, 1, E_BUB, 19);
    tbl[29] = v(0, 0, 0, 0, 1, E_BUB, 20);
    tbl[30] = v(0, 0, 0, 1, 1, E_NORM, 21);
    tbl[31] = v(0, 0, 0, 1, 0, E_FRZ, 21);  // leaving MEM_WAIT evaluates in the same cycle
    tbl[32] = v(0, 0, 0, 0, 1, E_IMS, 22);
    tbl[33] = v(0, 0, 0, 1, 1, E_NORM, 23);

    rst_n = 1'b0;
    drive(0, 0, 0, 1, 1);
    #2;
    chk("reset_outputs", E_RST, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_after_reset", E_NORM, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].hz, tbl[i].dep, tbl[i].br, tbl[i].im, tbl[i].dm);
      #1;
      chk($sformatf("table_%0d", i), tbl[i].ctl, tbl[i].sc);
    end

    // Reset asserted while a depth-3 stall still has two bubbles to go.
    @(negedge clk);
    drive(1, 3, 0, 1, 1);
    #1;
    chk("rst_seq_enter", E_BUB, 16'd23);
    @(negedge clk);
    drive(0, 0, 0, 1, 1);
    #1;
    chk("rst_seq_stall", E_BUB, 16'd24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", E_RST, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", E_NORM, 16'h0000);
    @(negedge clk);
    #1;
    chk("rst_release_next", E_NORM, 16'h0000);

    m_bub = 0;
    m_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      logic hz, br, im, dm;
      logic [1:0] dep;
      hz  = ($urandom % 4) == 0;
      dep = 2'($urandom % 4);
      br  = ($urandom % 8) == 0;
      im  = ($urandom % 5) != 0;
      dm  = ($urandom % 6) != 0;
      @(negedge clk);
      drive(hz, dep, br, im, dm);
      #1;
      model_step("random", hz, dep, br, im, dm);
    end

    // Saturation: preload near the top, then stall on instruction misses.
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      if (i == 0) begin
        force dut.u_stall_cnt.count_q = 16'hFFF0;
        #1;
        release dut.u_stall_cnt.count_q;
        m_cnt = 32'hFFF0;
      end else begin
        #1;
      end
      model_step("saturate", 0, 2'd0, 0, 0, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 1);
    #1;
    chk("sat_hold", E_NORM, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
